// File: rtl/if_types.sv
// if_types: shared fetch-stage FSM states and the canonical NOP encoding.
package if_types;
    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} if_state_t;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush inserts a NOP and keeps the last PC.
module if_id_reg
    import if_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    output logic [31:0] PC_out,
    output logic [31:0] instruction_out,
    output logic        false_NOP
);
    always_ff @(posedge clk) begin
        if (rst) begin
            PC_out          <= '0;
            instruction_out <= NOP_INSTR;
            false_NOP       <= 1'b1;
        end else if (flush) begin
            instruction_out <= NOP_INSTR;
            false_NOP       <= 1'b1;
        end else if (load) begin
            PC_out          <= pc_in;
            instruction_out <= instr_in;
            false_NOP       <= 1'b0;
        end
    end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the PC, drives the I-cache, absorbs stalls and squashes wrong-path fetches.
module instruction_fetch
    import if_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h00000060
) (
    input  logic        clk,
    input  logic        rst,
    output logic        icache_read,
    output logic [31:0] icache_address,
    input  logic [31:0] icache_rdata,
    input  logic        icache_resp,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        MA_stall,
    input  logic        bubble,
    output logic [31:0] PC_out,
    output logic [31:0] instruction_out,
    output logic        false_NOP,
    output logic        IF_stall
);
    if_state_t   state, state_n;
    logic [31:0] pc, pc_n, req_addr, req_n, instr_buf, buf_n, id_instr;
    logic        load, flush;
    logic        adv, redirect;

    assign adv            = !MA_stall && !bubble;
    assign redirect       = br_taken && !MA_stall;
    assign icache_read    = state != HOLD;
    assign icache_address = (state == DISCARD) ? req_addr : pc;
    assign IF_stall       = (state == FETCH && !icache_resp) || state == DISCARD;

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        req_n    = req_addr;
        buf_n    = instr_buf;
        load     = 1'b0;
        flush    = 1'b0;
        id_instr = icache_rdata;
        case (state)
            FETCH: begin
                if (redirect) begin
                    pc_n  = br_target;
                    flush = 1'b1;
                    if (!icache_resp) begin
                        req_n   = pc;
                        state_n = DISCARD;
                    end
                end else if (icache_resp && adv) begin
                    load = 1'b1;
                    pc_n = pc + 32'd4;
                end else if (icache_resp) begin
                    buf_n   = icache_rdata;
                    state_n = HOLD;
                end else begin
                    flush = adv;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_n    = br_target;
                    flush   = 1'b1;
                    state_n = FETCH;
                end else if (adv) begin
                    load     = 1'b1;
                    id_instr = instr_buf;
                    pc_n     = pc + 32'd4;
                    state_n  = FETCH;
                end
            end
            DISCARD: begin
                // The in-flight response belongs to the old path; only the pc tracks new redirects.
                flush   = adv || redirect;
                pc_n    = redirect ? br_target : pc;
                state_n = icache_resp ? FETCH : DISCARD;
            end
            default: state_n = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            req_addr  <= '0;
            instr_buf <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            req_addr  <= req_n;
            instr_buf <= buf_n;
        end
    end

    if_id_reg u_if_id (
        .clk             (clk),
        .rst             (rst),
        .load            (load),
        .flush           (flush),
        .pc_in           (pc),
        .instr_in        (id_instr),
        .PC_out          (PC_out),
        .instruction_out (instruction_out),
        .false_NOP       (false_NOP)
    );
endmodule
